io_mmap_ctrl: RTL and testbench



---
 rtl/io_mmap_ctrl_pkg.sv | 43 ++++
 rtl/io_mmap_ctrl_if.sv | 13 +
 rtl/io_rx_fifo.sv | 43 ++++
 rtl/io_mmap_ctrl.sv | 97 +++++++++
 tb/tb_io_mmap_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/io_mmap_ctrl_pkg.sv
// Shared register offsets, status bit positions and the offset decoder for the
// memory-mapped I/O slave.
package io_mmap_ctrl_pkg;

  localparam logic [31:0] IO_RX_CTRL = 32'h00;
  localparam logic [31:0] IO_RX_DATA = 32'h04;
  localparam logic [31:0] IO_TX_CTRL = 32'h08;
  localparam logic [31:0] IO_TX_DATA = 32'h0C;
  localparam logic [31:0] IO_CYC_CNT = 32'h10;
  localparam logic [31:0] IO_RET_CNT = 32'h14;
  localparam logic [31:0] IO_CNT_CLR = 32'h18;

  localparam int RX_NONEMPTY_BIT = 0;
  localparam int TX_FREE_BIT     = 0;

  typedef enum logic [2:0] {
    SEL_RX_CTRL,
    SEL_RX_DATA,
    SEL_TX_CTRL,
    SEL_TX_DATA,
    SEL_CYC_CNT,
    SEL_RET_CNT,
    SEL_CNT_CLR,
    SEL_NONE
  } reg_sel_e;

  // Byte-lane bits are dropped so any address inside a word selects that word.
  function automatic reg_sel_e decode_offset(input logic [31:0] offset);
    logic [31:0] word;
    word = {offset[31:2], 2'b00};
    case (word)
      IO_RX_CTRL: decode_offset = SEL_RX_CTRL;
      IO_RX_DATA: decode_offset = SEL_RX_DATA;
      IO_TX_CTRL: decode_offset = SEL_TX_CTRL;
      IO_TX_DATA: decode_offset = SEL_TX_DATA;
      IO_CYC_CNT: decode_offset = SEL_CYC_CNT;
      IO_RET_CNT: decode_offset = SEL_RET_CNT;
      IO_CNT_CLR: decode_offset = SEL_CNT_CLR;
      default:    decode_offset = SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/io_mmap_ctrl_if.sv
// Pipeline-side IO bus: X-stage address/strobes/store data in, M-stage load data out.
interface io_mmap_ctrl_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] io_addr;
  logic [3:0]        io_we;
  logic [31:0]       io_wdata;
  logic              io_re;
  logic [31:0]       io_rdata;

  modport master (output io_addr, io_we, io_wdata, io_re, input io_rdata);
  modport slave  (input io_addr, io_we, io_wdata, io_re, output io_rdata);
endinterface

// File: rtl/io_rx_fifo.sv
// Synchronous FIFO buffering UART receive bytes; pointers carry one extra wrap bit
// so full and empty are distinguishable without a separate count.
module io_rx_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] dout
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/io_mmap_ctrl.sv
// Memory-mapped IO slave: UART RX FIFO / TX holding register bridge plus cycle and
// retire counters, with a one-cycle registered read path into the M stage.
module io_mmap_ctrl
  import io_mmap_ctrl_pkg::*;
#(
  parameter int RX_DEPTH = 4,
  parameter int ADDR_W   = 8
) (
  input  logic           clk,
  input  logic           rst,
  io_mmap_ctrl_if.slave  bus,
  input  logic           instr_retire,
  input  logic [7:0]     rx_data,
  input  logic           rx_valid,
  output logic           rx_ready,
  output logic [7:0]     tx_data,
  output logic           tx_valid,
  input  logic           tx_ready
);

  logic [31:0] offset;
  reg_sel_e    sel;
  logic        wr_any, wr_tx, wr_clr, rd_pop;
  logic        fifo_full, fifo_empty;
  logic [7:0]  fifo_dout;
  logic [31:0] cyc_cnt, ret_cnt;
  logic [31:0] rd_val;
  logic        unused_wdata;

  assign offset       = 32'(bus.io_addr);
  assign sel          = decode_offset(offset);
  assign wr_any       = |bus.io_we;
  assign wr_tx        = wr_any && (sel == SEL_TX_DATA);
  assign wr_clr       = wr_any && (sel == SEL_CNT_CLR);
  assign rd_pop       = bus.io_re && (sel == SEL_RX_DATA);
  assign rx_ready     = !fifo_full;
  assign unused_wdata = ^bus.io_wdata[31:8];

  io_rx_fifo #(
    .DEPTH (RX_DEPTH),
    .W     (8)
  ) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (rx_valid),
    .din   (rx_data),
    .pop   (rd_pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .dout  (fifo_dout)
  );

  // A busy holding register only takes a new byte when the old one leaves this edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_valid <= 1'b0;
      tx_data  <= '0;
    end else if (wr_tx && (!tx_valid || tx_ready)) begin
      tx_valid <= 1'b1;
      tx_data  <= bus.io_wdata[7:0];
    end else if (tx_valid && tx_ready) begin
      tx_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else if (wr_clr) begin
      cyc_cnt <= '0;
      ret_cnt <= '0;
    end else begin
      cyc_cnt <= cyc_cnt + 32'd1;
      ret_cnt <= ret_cnt + 32'(instr_retire);
    end
  end

  always_comb begin
    rd_val = '0;
    case (sel)
      SEL_RX_CTRL: rd_val[RX_NONEMPTY_BIT] = !fifo_empty;
      SEL_RX_DATA: rd_val = fifo_empty ? 32'd0 : {24'd0, fifo_dout};
      SEL_TX_CTRL: rd_val[TX_FREE_BIT] = !tx_valid;
      SEL_CYC_CNT: rd_val = cyc_cnt;
      SEL_RET_CNT: rd_val = ret_cnt;
      default:     rd_val = '0;
    endcase
  end

  // Read data samples pre-edge state, so it lands in the M stage one cycle later.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            bus.io_rdata <= '0;
    else if (bus.io_re)  bus.io_rdata <= rd_val;
  end

endmodule

// File: tb/tb_io_mmap_ctrl.sv
// Directed bench for io_mmap_ctrl: a vector table for RX/TX/decode behaviour plus
// hand-written sequences for reset, counters, wrap and empty pop with push.
module tb_io_mmap_ctrl;
  import io_mmap_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       instr_retire;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  int n_chk  = 0;
  int n_fail = 0;

  io_mmap_ctrl_if #(.ADDR_W(8)) bus ();

  io_mmap_ctrl #(
    .RX_DEPTH (4),
    .ADDR_W   (8)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .bus          (bus),
    .instr_retire (instr_retire),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  addr;
    logic [3:0]  we;
    logic [31:0] wdata;
    logic        re;
    logic        rxv;
    logic [7:0]  rxd;
    logic        txr;
    logic [31:0] e_rdata;
    logic        e_rxr;
    logic        e_txv;
    logic [7:0]  e_txd;
    string       name;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic [7:0] addr, input logic [3:0] we,
                              input logic [31:0] wdata, input logic re,
                              input logic rxv, input logic [7:0] rxd, input logic txr,
                              input logic [31:0] e_rdata, input logic e_rxr,
                              input logic e_txv, input logic [7:0] e_txd,
                              input string name);
    vec_t v;
    v.addr = addr; v.we = we; v.wdata = wdata; v.re = re;
    v.rxv = rxv; v.rxd = rxd; v.txr = txr;
    v.e_rdata = e_rdata; v.e_rxr = e_rxr; v.e_txv = e_txv; v.e_txd = e_txd;
    v.name = name;
    vq.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    bus.io_addr  = '0;
    bus.io_we    = '0;
    bus.io_wdata = '0;
    bus.io_re    = 1'b0;
    rx_valid     = 1'b0;
    rx_data      = '0;
    tx_ready     = 1'b0;
    instr_retire = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string name);
    idle();
    bus.io_addr = addr;
    bus.io_re   = 1'b1;
    tick();
    check(name, bus.io_rdata, exp);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    idle();
    bus.io_addr  = addr;
    bus.io_we    = 4'b1111;
    bus.io_wdata = data;
    tick();
  endtask

  initial begin
    //  addr   we     wdata  re rxv rxd    txr  e_rdata  rxr txv txd    name
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h41, 0,   32'h00,  1,  0, 8'h00, "rx_push_41");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h42, 0,   32'h00,  1,  0, 8'h00, "rx_push_42");
    add(8'h00, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h01,  1,  0, 8'h00, "rx_ctrl_nonempty");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h41,  1,  0, 8'h00, "rx_pop_41");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h42,  1,  0, 8'h00, "rx_pop_42");
    add(8'h00, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  0, 8'h00, "rx_ctrl_empty");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  0, 8'h00, "rx_pop_empty");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h11, 0,   32'h00,  1,  0, 8'h00, "fill_1");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h22, 0,   32'h00,  1,  0, 8'h00, "fill_2");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h33, 0,   32'h00,  1,  0, 8'h00, "fill_3");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h44, 0,   32'h00,  0,  0, 8'h00, "fill_4_full");
    add(8'h00, 4'h0, 32'h0, 0, 1, 8'h55, 0,   32'h00,  0,  0, 8'h00, "fifth_held_off");
    add(8'h04, 4'h0, 32'h0, 1, 1, 8'h55, 0,   32'h11,  1,  0, 8'h00, "pop_push_full");
    add(8'h00, 4'h0, 32'h0, 0, 0, 8'h00, 0,   32'h11,  1,  0, 8'h00, "rdata_hold");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h22,  1,  0, 8'h00, "drain_22");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h33,  1,  0, 8'h00, "drain_33");
    add(8'h04, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h44,  1,  0, 8'h00, "drain_44");
    add(8'h00, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  0, 8'h00, "fifth_dropped");
    add(8'h0C, 4'h1, 32'h5A, 0, 0, 8'h00, 0,  32'h00,  1,  1, 8'h5A, "tx_load_5a");
    add(8'h08, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  1, 8'h5A, "tx_ctrl_busy");
    add(8'h0C, 4'h1, 32'h33, 0, 0, 8'h00, 0,  32'h00,  1,  1, 8'h5A, "tx_drop_33");
    add(8'h00, 4'h0, 32'h0, 0, 0, 8'h00, 1,   32'h00,  1,  0, 8'h5A, "tx_handshake");
    add(8'h08, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h01,  1,  0, 8'h5A, "tx_ctrl_free");
    add(8'h0C, 4'h2, 32'h77, 0, 0, 8'h00, 1,  32'h01,  1,  1, 8'h77, "tx_load_ready");
    add(8'h0C, 4'h8, 32'h99, 0, 0, 8'h00, 1,  32'h01,  1,  1, 8'h99, "tx_replace");
    add(8'h08, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  1, 8'h99, "tx_ctrl_busy2");
    add(8'h1C, 4'hF, 32'hAA, 0, 0, 8'h00, 1,  32'h00,  1,  0, 8'h99, "unmapped_wr_ignored");
    add(8'h0B, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h01,  1,  0, 8'h99, "tx_ctrl_bytelane");
    add(8'h1C, 4'h0, 32'h0, 1, 0, 8'h00, 0,   32'h00,  1,  0, 8'h99, "unmapped_rd");

    idle();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_rdata", bus.io_rdata, 32'h0);
    check("reset_tx_valid", 32'(tx_valid), 32'h0);
    check("reset_tx_data", 32'(tx_data), 32'h0);
    check("reset_rx_ready", 32'(rx_ready), 32'h1);
    rst = 1'b1;
    rd(IO_CYC_CNT[7:0], 32'h0, "reset_cyc_cnt");

    foreach (vq[i]) begin
      idle();
      bus.io_addr  = vq[i].addr;
      bus.io_we    = vq[i].we;
      bus.io_wdata = vq[i].wdata;
      bus.io_re    = vq[i].re;
      rx_valid     = vq[i].rxv;
      rx_data      = vq[i].rxd;
      tx_ready     = vq[i].txr;
      tick();
      check({vq[i].name, ".rdata"}, bus.io_rdata, vq[i].e_rdata);
      check({vq[i].name, ".rx_ready"}, 32'(rx_ready), 32'(vq[i].e_rxr));
      check({vq[i].name, ".tx_valid"}, 32'(tx_valid), 32'(vq[i].e_txv));
      check({vq[i].name, ".tx_data"}, 32'(tx_data), 32'(vq[i].e_txd));
    end

    // Counters over an exact window starting from a clear.
    wr(IO_CNT_CLR[7:0], 32'h0);
    for (int c = 0; c < 100; c++) begin
      idle();
      instr_retire = (c % 10 == 0);
      tick();
    end
    rd(IO_CYC_CNT[7:0], 32'd100, "cyc_cnt_100");
    rd(IO_RET_CNT[7:0], 32'd10, "ret_cnt_10");
    idle();
    bus.io_addr  = IO_CNT_CLR[7:0];
    bus.io_we    = 4'b0100;
    instr_retire = 1'b1;
    tick();
    rd(IO_CYC_CNT[7:0], 32'd0, "cyc_after_clr");
    rd(IO_CYC_CNT[7:0], 32'd1, "cyc_after_clr_plus1");
    rd(IO_RET_CNT[7:0], 32'd0, "ret_after_clr");

    // Cycle counter wrap.
    idle();
    force dut.cyc_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.cyc_cnt;
    rd(IO_CYC_CNT[7:0], 32'hFFFF_FFFF, "cyc_pre_wrap");
    rd(IO_CYC_CNT[7:0], 32'h0, "cyc_wrapped");

    // Empty pop with a simultaneous push keeps the pushed byte.
    idle();
    bus.io_addr = IO_RX_DATA[7:0];
    bus.io_re   = 1'b1;
    rx_valid    = 1'b1;
    rx_data     = 8'h7E;
    tick();
    check("empty_pop_push.rdata", bus.io_rdata, 32'h0);
    rd(IO_RX_DATA[7:0], 32'h7E, "empty_pop_push.retained");
    rd(IO_RX_CTRL[7:0], 32'h0, "empty_pop_push.drained");

    // Asynchronous reset mid-cycle with a pending TX byte and RX data queued.
    idle();
    rx_valid = 1'b1;
    rx_data  = 8'h12;
    tick();
    wr(IO_TX_DATA[7:0], 32'hAB);
    rd(IO_RX_CTRL[7:0], 32'h1, "pre_reset_rx_nonempty");
    check("pre_reset_tx_valid", 32'(tx_valid), 32'h1);
    idle();
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("async_rst_rdata", bus.io_rdata, 32'h0);
    check("async_rst_tx_valid", 32'(tx_valid), 32'h0);
    check("async_rst_tx_data", 32'(tx_data), 32'h0);
    check("async_rst_rx_ready", 32'(rx_ready), 32'h1);
    @(negedge clk);
    rst = 1'b1;
    rd(IO_CYC_CNT[7:0], 32'h0, "async_rst_cyc_cnt");
    rd(IO_RX_CTRL[7:0], 32'h0, "async_rst_fifo_empty");
    rd(IO_TX_CTRL[7:0], 32'h1, "async_rst_tx_free");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
